// File: rtl/axi_refill_if.sv
// AXI4 read-address / read-data channel bundle between the I-cache refill
// master and the interconnect.
interface axi_refill_if #(
    parameter int C_M_AXI_ID_WIDTH   = 4,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_M_AXI_ADDR_WIDTH = 32
);
    logic                          M_AXI_ARVALID;
    logic                          M_AXI_ARREADY;
    logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID;
    logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [7:0]                    M_AXI_ARLEN;
    logic [2:0]                    M_AXI_ARSIZE;
    logic [1:0]                    M_AXI_ARBURST;
    logic                          M_AXI_RVALID;
    logic                          M_AXI_RREADY;
    logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID;
    logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]                    M_AXI_RRESP;
    logic                          M_AXI_RLAST;

    modport master (
        output M_AXI_ARVALID, M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN,
               M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_RREADY,
        input  M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RID, M_AXI_RDATA,
               M_AXI_RRESP, M_AXI_RLAST
    );

    modport slave (
        input  M_AXI_ARVALID, M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN,
               M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_RREADY,
        output M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RID, M_AXI_RDATA,
               M_AXI_RRESP, M_AXI_RLAST
    );
endinterface

// File: rtl/axi_refill_master.sv
// I-cache line refill master: one INCR read burst per miss, beats streamed
// back to the cache with a completion/error pulse at the end.
module axi_refill_master #(
    parameter int C_M_AXI_ID_WIDTH   = 4,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int LINE_BEATS         = 4,
    parameter int AXI_ID             = 0
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic                          flush,
    output logic                          rd_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rd_data,
    output logic                          rd_last,
    output logic                          done,
    output logic                          done_err,
    axi_refill_if.master                  m_axi
);
    localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_BEATS * C_M_AXI_DATA_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_BEATS - 1);
    localparam logic [C_M_AXI_ID_WIDTH-1:0] ID_VAL = C_M_AXI_ID_WIDTH'(AXI_ID);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] OFF_MASK =
        C_M_AXI_ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    state_t                          state_reg, state_next;
    logic                            arvalid_reg, arvalid_next;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_reg, araddr_next;
    logic                            rready_reg, rready_next;
    logic                            rd_valid_reg, rd_valid_next;
    logic                            rd_last_reg, rd_last_next;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data_reg, rd_data_next;
    logic                            done_reg, done_next;
    logic                            done_err_reg, done_err_next;
    logic [CNT_W-1:0]                cnt_reg, cnt_next;
    logic                            err_reg, err_next;
    logic                            flush_seen_reg, flush_seen_next;
    logic                            r_hs;
    logic                            beat_err;

    assign r_hs     = m_axi.M_AXI_RVALID && rready_reg;
    assign beat_err = (m_axi.M_AXI_RRESP != 2'b00) ||
                      (m_axi.M_AXI_RID != ID_VAL) ||
                      (m_axi.M_AXI_RLAST != (cnt_reg == LAST_CNT));

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_reg      <= IDLE;
            arvalid_reg    <= 1'b0;
            araddr_reg     <= '0;
            rready_reg     <= 1'b0;
            rd_valid_reg   <= 1'b0;
            rd_last_reg    <= 1'b0;
            rd_data_reg    <= '0;
            done_reg       <= 1'b0;
            done_err_reg   <= 1'b0;
            cnt_reg        <= '0;
            err_reg        <= 1'b0;
            flush_seen_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            arvalid_reg    <= arvalid_next;
            araddr_reg     <= araddr_next;
            rready_reg     <= rready_next;
            rd_valid_reg   <= rd_valid_next;
            rd_last_reg    <= rd_last_next;
            rd_data_reg    <= rd_data_next;
            done_reg       <= done_next;
            done_err_reg   <= done_err_next;
            cnt_reg        <= cnt_next;
            err_reg        <= err_next;
            flush_seen_reg <= flush_seen_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        arvalid_next    = arvalid_reg;
        araddr_next     = araddr_reg;
        rready_next     = rready_reg;
        rd_valid_next   = 1'b0;
        rd_last_next    = 1'b0;
        rd_data_next    = rd_data_reg;
        done_next       = 1'b0;
        done_err_next   = 1'b0;
        cnt_next        = cnt_reg;
        err_next        = err_reg;
        flush_seen_next = flush_seen_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid && !flush) begin
                    araddr_next     = req_addr & ~OFF_MASK;
                    arvalid_next    = 1'b1;
                    cnt_next        = '0;
                    err_next        = 1'b0;
                    flush_seen_next = 1'b0;
                    state_next      = ADDR;
                end
            end
            ADDR: begin
                // A flush cannot cancel an address already offered; remember it.
                if (flush) begin
                    flush_seen_next = 1'b1;
                end
                if (m_axi.M_AXI_ARREADY) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = (flush || flush_seen_reg) ? DRAIN : DATA;
                end
            end
            DATA: begin
                if (flush) begin
                    // The beat taken alongside a flush is dropped; if it closed the burst there is nothing to drain.
                    state_next = DRAIN;
                    if (r_hs && m_axi.M_AXI_RLAST) begin
                        state_next  = IDLE;
                        rready_next = 1'b0;
                    end
                end else if (r_hs) begin
                    rd_valid_next = 1'b1;
                    rd_data_next  = m_axi.M_AXI_RDATA;
                    err_next      = err_reg | beat_err;
                    if (m_axi.M_AXI_RLAST) begin
                        rd_last_next  = 1'b1;
                        done_next     = 1'b1;
                        done_err_next = err_reg | beat_err;
                        cnt_next      = '0;
                        rready_next   = 1'b0;
                        state_next    = IDLE;
                    end else if (cnt_reg == LAST_CNT) begin
                        rd_last_next  = 1'b1;
                        done_next     = 1'b1;
                        done_err_next = 1'b1;
                        cnt_next      = '0;
                        state_next    = DRAIN;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (r_hs && m_axi.M_AXI_RLAST) begin
                    rready_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state_reg == IDLE) && !flush;
    assign rd_valid  = rd_valid_reg;
    assign rd_data   = rd_data_reg;
    assign rd_last   = rd_last_reg;
    assign done      = done_reg;
    assign done_err  = done_err_reg;

    assign m_axi.M_AXI_ARVALID = arvalid_reg;
    assign m_axi.M_AXI_ARADDR  = araddr_reg;
    assign m_axi.M_AXI_ARID    = ID_VAL;
    assign m_axi.M_AXI_ARLEN   = 8'(LINE_BEATS - 1);
    assign m_axi.M_AXI_ARSIZE  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    assign m_axi.M_AXI_ARBURST = 2'b01;
    assign m_axi.M_AXI_RREADY  = rready_reg;
endmodule

// File: doc/axi_refill_master.md
Name: axi_refill_master

Overview:
- AXI4 read-only burst master that refills one instruction-cache line.
- Takes a line-miss request from the I-cache, issues a single INCR burst on the AR channel, and collects R beats.
- Streams beats back to the cache and reports completion status.
- Sits between the I-cache and the AXI interconnect/slave memory. Exactly one burst is outstanding at a time.

Parameters:
C_M_AXI_ID_WIDTH, 4, width of ARID/RID
C_M_AXI_DATA_WIDTH, 64, R data width (32 or 64)
C_M_AXI_ADDR_WIDTH, 32, address width
LINE_BEATS, 4, beats per line; power of 2, range 1..256
AXI_ID, 0, constant ID driven on ARID and expected on RID

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  reset; asynchronous, active-low
req_valid  in  1  line refill request
req_ready  out  1  request accepted when req_valid && req_ready
req_addr  in  C_M_AXI_ADDR_WIDTH  miss address (any byte)
flush  in  1  abort current refill; its data is discarded
rd_valid  out  1  one refill beat valid (one-cycle pulse per beat)
rd_data  out  C_M_AXI_DATA_WIDTH  beat data
rd_last  out  1  final beat of line, qualified by rd_valid
done  out  1  one-cycle pulse: refill complete
done_err  out  1  error status, qualified by done
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_ARID  out  C_M_AXI_ID_WIDTH  constant AXI_ID
M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  line-aligned address
M_AXI_ARLEN  out  8  constant LINE_BEATS-1
M_AXI_ARSIZE  out  3  constant log2(C_M_AXI_DATA_WIDTH/8)
M_AXI_ARBURST  out  2  constant 2'b01 (INCR)
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready
M_AXI_RID  in  C_M_AXI_ID_WIDTH  read ID
M_AXI_RDATA  in  C_M_AXI_DATA_WIDTH  read data
M_AXI_RRESP  in  2  read response
M_AXI_RLAST  in  1  last beat

Behaviour:
- Reset (ARESETN low, async):
  - state = IDLE.
  - ARVALID, RREADY, rd_valid, rd_last, done, done_err, ARADDR, rd_data, beat counter and error flag all 0.
- FSM states: IDLE, ADDR, DATA, DRAIN.
- req_ready = (state==IDLE) && !flush, combinational.
- IDLE:
  - On accept at cycle T, latch req_addr with its low log2(LINE_BEATS*C_M_AXI_DATA_WIDTH/8) bits cleared into ARADDR.
  - ARVALID=1 at T+1; state goes to ADDR. Clear beat counter and error flag.
- ADDR:
  - ARVALID and ARADDR are held stable until ARREADY; ARVALID is never withdrawn.
  - On handshake: ARVALID=0 and RREADY=1 next cycle. Next state is DATA, or DRAIN if a flush was seen.
- DATA:
  - RREADY=1. Each beat (RVALID && RREADY) at cycle t gives rd_valid=1 and rd_data=RDATA at t+1. Beat counter increments.
  - beat_err = (RRESP!=2'b00) || (RID!=AXI_ID) || (RLAST != (cnt==LINE_BEATS-1)). beat_err is ORed into a sticky error flag.
  - Normal end (cnt==LINE_BEATS-1 with RLAST): at t+1, rd_last=1, done=1, done_err = sticky flag including this beat. State goes to IDLE and RREADY=0.
  - Early RLAST (cnt<LINE_BEATS-1): treat as burst end. At t+1: rd_valid=1, rd_last=1, done=1, done_err=1. State goes to IDLE.
  - Missing RLAST on final counted beat: done_err=1. State goes to DRAIN, which consumes beats until RLAST.
- flush:
  - Ignored in IDLE.
  - In ADDR: remembered; the AR handshake still completes, then state goes to DRAIN.
  - In DATA: state goes to DRAIN next cycle. A beat handshaking in the same cycle as flush is discarded (no rd_valid).
- DRAIN:
  - RREADY=1; beats are accepted with no rd_valid.
  - On RLAST: state goes to IDLE and RREADY=0.
  - No done pulse for flushed refills. done is issued for the missing-RLAST error case.
- Minimum latency with ARREADY=1 and RVALID=1 always:
  - Accept at T; ARVALID at T+1; RREADY at T+2.
  - First rd_valid at T+3; done at T+2+LINE_BEATS.
- Counter width = max(1, log2(LINE_BEATS)); the counter wraps only on burst end.
- Reset mid-burst: immediate return to IDLE with all outputs 0. The slave shares the reset domain, so no drain is required.

Test Plan:
- Basic refill: req_addr=0x8000_0014, ARREADY=1, 4 OKAY beats D0..D3 with RLAST on beat 3 -> ARADDR=0x8000_0000, ARLEN=3, ARSIZE=3, ARBURST=1; rd_data D0..D3 in order; rd_last and done on D3; done_err=0; done at T+6.
- Backpressure: ARREADY delayed 5 cycles, RVALID gaps of 2 cycles -> ARVALID/ARADDR stable until handshake; exactly 4 rd_valid pulses; one done.
- Error: beat 1 RRESP=2'b10 -> all 4 beats forwarded; done_err=1 on done.
- Early RLAST on beat 1 -> rd_last at beat 1, done=1, done_err=1; next request accepted the cycle after done.
- Flush in ADDR and in DATA after beat 1 -> no further rd_valid, no done; RREADY held until RLAST; req_ready=1 the cycle after RLAST.
- Async reset asserted mid-DATA -> ARVALID, RREADY, rd_valid and done are 0 immediately; after release, a new refill completes normally.
